// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port, word-wide, fixed-latency memory between the
// instruction-fetch port (IF) and the load/store data port (D). The data port
// has priority. A starvation counter forces an IF win after STARVE_LIMIT
// consecutive data grants taken while IF was also requesting.
//
// Only one transaction is outstanding at a time:
//   IDLE/RESP (arbitrate) -> ISSUE -> WAIT (MEM_LATENCY-1 cycles) -> CAPT -> RESP
// The grant pulse is visible in the cycle after the arbitration decision
// (ISSUE). rvalid is visible in RESP, MEM_LATENCY+2 cycles after that decision.
// RESP also arbitrates, so transfers can run back to back.
//
// Optional feature (compile-time macro MEM_ARB_ALIGN_CHECK_EN):
//   Misaligned accesses are still granted but never reach memory. They go
//   ISSUE -> RESP and return rdata=0 with rvalid and err high together. With
//   the macro undefined the err port does not exist and addr[1:0] is ignored.
//
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   if_req/if_addr  fetch request (held until if_gnt), byte address
//   if_gnt          one-cycle fetch accept pulse
//   if_rvalid       one-cycle fetch response pulse, if_rdata valid with it
//   d_req/d_we/d_be/d_addr/d_wdata
//                   data request (held until d_gnt), store flag, byte enables,
//                   byte address, store data
//   d_gnt           one-cycle data accept pulse
//   d_rvalid        one-cycle data response pulse (also acknowledges stores),
//                   d_rdata valid with it (0 for stores)
//   mem_en/mem_we/mem_be/mem_addr/mem_wdata
//                   memory strobe, write enable, byte enables, word address,
//                   write data
//   mem_rdata       memory read data, valid MEM_LATENCY cycles after mem_en
//   busy            high whenever the FSM is not IDLE
//   err             misaligned-access pulse (macro builds only)
// All outputs are registered.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef MEM_ARB_ALIGN_CHECK_EN
  ,
  output logic              err
`endif
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam int WA_W = ADDR_W - 2;

  // Elaboration-time parameter checks
  generate
    if (DATA_W != 32) begin : g_bad_data_w
      $error("mem_port_arbiter: DATA_W must be 32");
    end
    if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : g_bad_latency
      $error("mem_port_arbiter: MEM_LATENCY must be in 1..4");
    end
    if (STARVE_LIMIT < 1) begin : g_bad_starve
      $error("mem_port_arbiter: STARVE_LIMIT must be at least 1");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPT, RESP} state_t;

  state_t            state_reg, state_next;
  logic [SC_W-1:0]   starve_cnt_reg, starve_cnt_next;
  logic [1:0]        lat_cnt_reg, lat_cnt_next;
  logic              owner_d_reg, owner_d_next;     // 1 = data port owns the transaction
  logic [WA_W-1:0]   cap_waddr_reg, cap_waddr_next;
  logic              cap_we_reg, cap_we_next;
  logic [3:0]        cap_be_reg, cap_be_next;
  logic [DATA_W-1:0] cap_wdata_reg, cap_wdata_next;
  logic              misalign_reg, misalign_next;

  logic arb_point;
  logic grant_if;
  logic grant_d;
  logic misalign_win;

  assign arb_point = (state_reg == IDLE) || (state_reg == RESP);
  assign grant_if  = arb_point && if_req &&
                     (!d_req || (starve_cnt_reg == SC_W'(STARVE_LIMIT)));
  assign grant_d   = arb_point && d_req && !grant_if;

`ifdef MEM_ARB_ALIGN_CHECK_EN
  // Misalignment of whichever request wins this arbitration
  always_comb begin
    misalign_win = 1'b0;
    if (grant_if) begin
      misalign_win = (if_addr[1:0] != 2'b00);
    end else if (grant_d) begin
      misalign_win = ((d_be == 4'b1111) && (d_addr[1:0] != 2'b00)) ||
                     (((d_be == 4'b0011) || (d_be == 4'b1100)) && d_addr[0]);
    end
  end
`else
  // Byte offset bits are intentionally ignored in this build
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{if_addr[1:0], d_addr[1:0]};
  assign misalign_win     = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= IDLE;
      starve_cnt_reg <= '0;
      lat_cnt_reg    <= '0;
      owner_d_reg    <= 1'b0;
      cap_waddr_reg  <= '0;
      cap_we_reg     <= 1'b0;
      cap_be_reg     <= '0;
      cap_wdata_reg  <= '0;
      misalign_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
      lat_cnt_reg    <= lat_cnt_next;
      owner_d_reg    <= owner_d_next;
      cap_waddr_reg  <= cap_waddr_next;
      cap_we_reg     <= cap_we_next;
      cap_be_reg     <= cap_be_next;
      cap_wdata_reg  <= cap_wdata_next;
      misalign_reg   <= misalign_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic, including arbitration and request capture
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    starve_cnt_next = starve_cnt_reg;
    lat_cnt_next    = lat_cnt_reg;
    owner_d_next    = owner_d_reg;
    cap_waddr_next  = cap_waddr_reg;
    cap_we_next     = cap_we_reg;
    cap_be_next     = cap_be_reg;
    cap_wdata_next  = cap_wdata_reg;
    misalign_next   = misalign_reg;

    case (state_reg)
      IDLE, RESP: begin
        // The counter only tracks data wins taken while IF was waiting
        if (!if_req || grant_if) begin
          starve_cnt_next = '0;
        end else if (grant_d) begin
          starve_cnt_next = starve_cnt_reg + SC_W'(1);
        end

        if (grant_if || grant_d) begin
          state_next     = ISSUE;
          owner_d_next   = grant_d;
          misalign_next  = misalign_win;
          cap_waddr_next = grant_d ? d_addr[ADDR_W-1:2] : if_addr[ADDR_W-1:2];
          cap_we_next    = grant_d && d_we;
          cap_be_next    = grant_d ? d_be : 4'b1111;
          cap_wdata_next = grant_d ? d_wdata : '0;
        end else begin
          state_next = IDLE;
        end
      end

      ISSUE: begin
        lat_cnt_next = '0;
        if (misalign_reg) begin
          state_next = RESP;
        end else if (MEM_LATENCY > 1) begin
          state_next = WAIT;
        end else begin
          state_next = CAPT;
        end
      end

      WAIT: begin
        // WAIT occupies MEM_LATENCY-1 cycles: counter values 0..MEM_LATENCY-2
        if (lat_cnt_reg == 2'(MEM_LATENCY - 2)) begin
          state_next = CAPT;
        end else begin
          lat_cnt_next = lat_cnt_reg + 2'd1;
        end
      end

      CAPT: begin
        state_next = RESP;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: next values are decoded from the upcoming state so that the
  // registered outputs line up with the state they belong to.
  // ---------------------------------------------------------------------------
  logic              if_gnt_next, d_gnt_next;
  logic              if_rvalid_next, d_rvalid_next;
  logic [DATA_W-1:0] if_rdata_next, d_rdata_next;
  logic              mem_en_next, mem_we_next;
  logic [3:0]        mem_be_next;
  logic [WA_W-1:0]   mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_next;
  logic              busy_next;
  logic              err_next;

  always_comb begin
    if_gnt_next    = (state_next == ISSUE) && !owner_d_next;
    d_gnt_next     = (state_next == ISSUE) &&  owner_d_next;
    if_rvalid_next = (state_next == RESP)  && !owner_d_next;
    d_rvalid_next  = (state_next == RESP)  &&  owner_d_next;
    err_next       = (state_next == RESP)  &&  misalign_next;
    busy_next      = (state_next != IDLE);

    mem_en_next    = (state_next == ISSUE) && !misalign_next;
    mem_we_next    = mem_en_next && cap_we_next;
    mem_be_next    = mem_en_next ? cap_be_next    : 4'b0000;
    mem_addr_next  = mem_en_next ? cap_waddr_next : '0;
    mem_wdata_next = mem_en_next ? cap_wdata_next : '0;

    // rdata holds between responses; it is loaded once per transaction
    if_rdata_next = if_rdata;
    d_rdata_next  = d_rdata;
    if (state_reg == CAPT) begin
      if (owner_d_reg) begin
        d_rdata_next = cap_we_reg ? '0 : mem_rdata;
      end else begin
        if_rdata_next = mem_rdata;
      end
    end else if ((state_reg == ISSUE) && misalign_reg) begin
      if (owner_d_reg) begin
        d_rdata_next = '0;
      end else begin
        if_rdata_next = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      if_gnt    <= if_gnt_next;
      d_gnt     <= d_gnt_next;
      if_rvalid <= if_rvalid_next;
      d_rvalid  <= d_rvalid_next;
      if_rdata  <= if_rdata_next;
      d_rdata   <= d_rdata_next;
      mem_en    <= mem_en_next;
      mem_we    <= mem_we_next;
      mem_be    <= mem_be_next;
      mem_addr  <= mem_addr_next;
      mem_wdata <= mem_wdata_next;
      busy      <= busy_next;
    end
  end

`ifdef MEM_ARB_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      err <= 1'b0;
    end else begin
      err <= err_next;
    end
  end
`else
  logic unused_err;
  assign unused_err = err_next;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for mem_port_arbiter.
// Instance a: MEM_LATENCY=1, driven from a cycle-by-cycle vector table, then a
//             starvation sequence (and an alignment sequence in macro builds).
// Instance b: MEM_LATENCY=3, reset asserted while an access waits in WAIT.
// Each vector gives the inputs for one cycle and the outputs expected right
// after the clock edge that samples them.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- instance a (MEM_LATENCY = 1) ----------------
  logic        a_rst, a_if_req, a_d_req, a_d_we;
  logic [7:0]  a_if_addr, a_d_addr;
  logic [3:0]  a_d_be;
  logic [31:0] a_d_wdata;
  logic        a_if_gnt, a_if_rvalid, a_d_gnt, a_d_rvalid;
  logic [31:0] a_if_rdata, a_d_rdata;
  logic        a_mem_en, a_mem_we, a_busy;
  logic [3:0]  a_mem_be;
  logic [5:0]  a_mem_addr;
  logic [31:0] a_mem_wdata, a_mem_rdata;
`ifdef MEM_ARB_ALIGN_CHECK_EN
  logic        a_err, b_err;
`endif

  // ---------------- instance b (MEM_LATENCY = 3) ----------------
  logic        b_rst, b_if_req, b_d_req, b_d_we;
  logic [7:0]  b_if_addr, b_d_addr;
  logic [3:0]  b_d_be;
  logic [31:0] b_d_wdata;
  logic        b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid;
  logic [31:0] b_if_rdata, b_d_rdata;
  logic        b_mem_en, b_mem_we, b_busy;
  logic [3:0]  b_mem_be;
  logic [5:0]  b_mem_addr;
  logic [31:0] b_mem_wdata, b_mem_rdata;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LATENCY(1), .STARVE_LIMIT(4)) dut_a (
    .clk(clk), .rst(a_rst),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
    .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
    .d_req(a_d_req), .d_we(a_d_we), .d_be(a_d_be), .d_addr(a_d_addr),
    .d_wdata(a_d_wdata), .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_be(a_mem_be), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
`ifdef MEM_ARB_ALIGN_CHECK_EN
    , .err(a_err)
`endif
  );

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LATENCY(3), .STARVE_LIMIT(4)) dut_b (
    .clk(clk), .rst(b_rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_be(b_d_be), .d_addr(b_d_addr),
    .d_wdata(b_d_wdata), .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_be(b_mem_be), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
`ifdef MEM_ARB_ALIGN_CHECK_EN
    , .err(b_err)
`endif
  );

  // ---------------- memory models ----------------
  logic [31:0] mem_a [0:63];
  logic [31:0] mem_b [0:63];
  logic [31:0] a_rd = 32'h0;
  logic [31:0] b_s0 = 32'h0, b_s1 = 32'h0, b_s2 = 32'h0;

  assign a_mem_rdata = a_rd;   // one cycle after mem_en
  assign b_mem_rdata = b_s2;   // three cycles after mem_en

  always @(posedge clk) begin
    if (a_mem_en) begin
      if (a_mem_we) begin
        for (int k = 0; k < 4; k++)
          if (a_mem_be[k]) mem_a[a_mem_addr][k*8 +: 8] <= a_mem_wdata[k*8 +: 8];
      end
      a_rd <= mem_a[a_mem_addr];
    end
    if (b_mem_en && b_mem_we) begin
      for (int k = 0; k < 4; k++)
        if (b_mem_be[k]) mem_b[b_mem_addr][k*8 +: 8] <= b_mem_wdata[k*8 +: 8];
    end
    b_s0 <= b_mem_en ? mem_b[b_mem_addr] : 32'h0;
    b_s1 <= b_s0;
    b_s2 <= b_s1;
  end

  // ---------------- vector table ----------------
  // ctl = {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, busy}
  typedef struct {
    logic        rst;
    logic        if_req;
    logic [7:0]  if_addr;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [7:0]  d_addr;
    logic [31:0] d_wdata;
    logic [6:0]  ctl;
    logic [3:0]  be;
    logic [5:0]  maddr;
    logic [31:0] mwdata;
    logic [31:0] if_rd;
    logic [31:0] d_rd;
  } vec_t;

  localparam int NV = 20;
  vec_t vec [NV];

  function automatic vec_t mk(input logic rst, input logic ifr, input logic [7:0] ifa,
                              input logic dr, input logic dwe, input logic [3:0] dbe,
                              input logic [7:0] da, input logic [31:0] dwd,
                              input logic [6:0] ctl, input logic [3:0] be,
                              input logic [5:0] ma, input logic [31:0] mwd,
                              input logic [31:0] ifrd, input logic [31:0] drd);
    vec_t v;
    v.rst = rst; v.if_req = ifr; v.if_addr = ifa; v.d_req = dr; v.d_we = dwe;
    v.d_be = dbe; v.d_addr = da; v.d_wdata = dwd; v.ctl = ctl; v.be = be;
    v.maddr = ma; v.mwdata = mwd; v.if_rd = ifrd; v.d_rd = drd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic exp_d [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    int n;
    int last_cyc;
    logic done;

    for (int i = 0; i < 64; i++) begin
      mem_a[i] = 32'h0;
      mem_b[i] = 32'h0;
    end
    mem_a[0] = 32'hA5A5_0000;
    mem_a[2] = 32'hDEAD_BEEF;
    mem_a[4] = 32'h1111_2222;
    mem_b[2] = 32'hCAFE_F00D;

    b_rst = 1'b0; b_if_req = 1'b0; b_if_addr = 8'h0; b_d_req = 1'b0;
    b_d_we = 1'b0; b_d_be = 4'h0; b_d_addr = 8'h0; b_d_wdata = 32'h0;

    //            rst ifr ifa    dr we be      da     dwd           ctl         be      ma  mwd           if_rd         d_rd
    vec[0]  = mk(0, 1, 8'h00, 1, 0, 4'hF,   8'h08, 32'h0,        7'b0000000, 4'h0,   0,  32'h0,        32'h0,        32'h0);
    vec[1]  = mk(0, 1, 8'h00, 1, 0, 4'hF,   8'h08, 32'h0,        7'b0000000, 4'h0,   0,  32'h0,        32'h0,        32'h0);
    vec[2]  = mk(0, 1, 8'h00, 1, 0, 4'hF,   8'h08, 32'h0,        7'b0000000, 4'h0,   0,  32'h0,        32'h0,        32'h0);
    vec[3]  = mk(1, 1, 8'h00, 1, 0, 4'hF,   8'h08, 32'h0,        7'b0100101, 4'hF,   2,  32'h0,        32'h0,        32'h0);
    vec[4]  = mk(1, 1, 8'h00, 0, 0, 4'hF,   8'h08, 32'h0,        7'b0000001, 4'h0,   0,  32'h0,        32'h0,        32'h0);
    vec[5]  = mk(1, 1, 8'h00, 0, 0, 4'hF,   8'h08, 32'h0,        7'b0001001, 4'h0,   0,  32'h0,        32'h0,        32'hDEADBEEF);
    vec[6]  = mk(1, 1, 8'h00, 0, 0, 4'hF,   8'h08, 32'h0,        7'b1000101, 4'hF,   0,  32'h0,        32'h0,        32'hDEADBEEF);
    vec[7]  = mk(1, 0, 8'h00, 0, 0, 4'hF,   8'h08, 32'h0,        7'b0000001, 4'h0,   0,  32'h0,        32'h0,        32'hDEADBEEF);
    vec[8]  = mk(1, 0, 8'h00, 0, 0, 4'hF,   8'h08, 32'h0,        7'b0010001, 4'h0,   0,  32'h0,        32'hA5A50000, 32'hDEADBEEF);
    vec[9]  = mk(1, 0, 8'h00, 0, 0, 4'hF,   8'h08, 32'h0,        7'b0000000, 4'h0,   0,  32'h0,        32'hA5A50000, 32'hDEADBEEF);
    vec[10] = mk(1, 1, 8'h08, 0, 0, 4'hF,   8'h08, 32'h0,        7'b1000101, 4'hF,   2,  32'h0,        32'hA5A50000, 32'hDEADBEEF);
    vec[11] = mk(1, 0, 8'h08, 0, 0, 4'hF,   8'h08, 32'h0,        7'b0000001, 4'h0,   0,  32'h0,        32'hA5A50000, 32'hDEADBEEF);
    vec[12] = mk(1, 0, 8'h08, 0, 0, 4'hF,   8'h08, 32'h0,        7'b0010001, 4'h0,   0,  32'h0,        32'hDEADBEEF, 32'hDEADBEEF);
    vec[13] = mk(1, 0, 8'h08, 1, 1, 4'b0011, 8'h10, 32'h0000ABCD, 7'b0100111, 4'b0011, 4, 32'h0000ABCD, 32'hDEADBEEF, 32'hDEADBEEF);
    vec[14] = mk(1, 1, 8'h0C, 1, 0, 4'hF,   8'h10, 32'h0,        7'b0000001, 4'h0,   0,  32'h0,        32'hDEADBEEF, 32'hDEADBEEF);
    vec[15] = mk(1, 1, 8'h0C, 1, 0, 4'hF,   8'h10, 32'h0,        7'b0001001, 4'h0,   0,  32'h0,        32'hDEADBEEF, 32'h0);
    vec[16] = mk(1, 0, 8'h0C, 1, 0, 4'hF,   8'h10, 32'h0,        7'b0100101, 4'hF,   4,  32'h0,        32'hDEADBEEF, 32'h0);
    vec[17] = mk(1, 0, 8'h0C, 0, 0, 4'hF,   8'h10, 32'h0,        7'b0000001, 4'h0,   0,  32'h0,        32'hDEADBEEF, 32'h0);
    vec[18] = mk(1, 0, 8'h0C, 0, 0, 4'hF,   8'h10, 32'h0,        7'b0001001, 4'h0,   0,  32'h0,        32'hDEADBEEF, 32'h1111ABCD);
    vec[19] = mk(1, 0, 8'h0C, 0, 0, 4'hF,   8'h10, 32'h0,        7'b0000000, 4'h0,   0,  32'h0,        32'hDEADBEEF, 32'h1111ABCD);

    for (int i = 0; i < NV; i++) begin
      a_rst = vec[i].rst; a_if_req = vec[i].if_req; a_if_addr = vec[i].if_addr;
      a_d_req = vec[i].d_req; a_d_we = vec[i].d_we; a_d_be = vec[i].d_be;
      a_d_addr = vec[i].d_addr; a_d_wdata = vec[i].d_wdata;
      @(posedge clk); #1;
      chk($sformatf("v%0d ctl", i),
          32'({a_if_gnt, a_d_gnt, a_if_rvalid, a_d_rvalid, a_mem_en, a_mem_we, a_busy}),
          32'(vec[i].ctl));
      chk($sformatf("v%0d mem_be", i),    32'(a_mem_be),   32'(vec[i].be));
      chk($sformatf("v%0d mem_addr", i),  32'(a_mem_addr), 32'(vec[i].maddr));
      chk($sformatf("v%0d mem_wdata", i), a_mem_wdata,     vec[i].mwdata);
      chk($sformatf("v%0d if_rdata", i),  a_if_rdata,      vec[i].if_rd);
      chk($sformatf("v%0d d_rdata", i),   a_d_rdata,       vec[i].d_rd);
      $display("vector %0d: gnt if/d=%b/%b rvalid if/d=%b/%b mem_en=%b busy=%b",
               i, a_if_gnt, a_d_gnt, a_if_rvalid, a_d_rvalid, a_mem_en, a_busy);
    end

    // ---------------- starvation: both ports held requesting ----------------
    a_if_req = 1'b1; a_if_addr = 8'h00;
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_be = 4'hF; a_d_addr = 8'h08; a_d_wdata = 32'h0;
    n = 0;
    last_cyc = 0;
    for (int cyc = 0; cyc < 100 && n < 10; cyc++) begin
      @(posedge clk); #1;
      chk("gnt exclusive", 32'(a_if_gnt & a_d_gnt), 32'h0);
      chk("rvalid exclusive", 32'(a_if_rvalid & a_d_rvalid), 32'h0);
      if (a_if_gnt || a_d_gnt) begin
        chk($sformatf("starve grant %0d is D", n), 32'(a_d_gnt), 32'(exp_d[n]));
        if (n > 0) chk($sformatf("starve grant %0d spacing", n), 32'(cyc - last_cyc), 32'd3);
        $display("grant %0d: %s", n, a_d_gnt ? "D" : "IF");
        last_cyc = cyc;
        n++;
      end
    end
    if (n < 10) begin
      checks++; errors++;
      $display("FAIL starve timeout: got %0d grants, expected 10", n);
    end
    a_if_req = 1'b0; a_d_req = 1'b0;
    done = 1'b0;
    for (int cyc = 0; cyc < 20 && !done; cyc++) begin
      @(posedge clk); #1;
      if (!a_busy) done = 1'b1;
    end
    chk("starve drain busy", 32'(a_busy), 32'h0);

`ifdef MEM_ARB_ALIGN_CHECK_EN
    // ---------------- misaligned word store ----------------
    a_d_req = 1'b1; a_d_we = 1'b1; a_d_be = 4'hF; a_d_addr = 8'h06; a_d_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    chk("align d_gnt", 32'(a_d_gnt), 32'h1);
    chk("align mem_en", 32'(a_mem_en), 32'h0);
    a_d_req = 1'b0;
    @(posedge clk); #1;
    chk("align rvalid+err", 32'({a_d_rvalid, a_err}), 32'h3);
    chk("align d_rdata", a_d_rdata, 32'h0);
    $display("align: misaligned store answered with err");
    @(posedge clk); #1;
    chk("align err pulse", 32'(a_err), 32'h0);
`endif

    // ---------------- reset during WAIT (MEM_LATENCY = 3) ----------------
    b_rst = 1'b1; b_if_req = 1'b1; b_if_addr = 8'h08;
    @(posedge clk); #1;
    chk("b fetch gnt", 32'({b_if_gnt, b_mem_en, b_mem_addr}), 32'({1'b1, 1'b1, 6'd2}));
    b_if_req = 1'b0;
    @(posedge clk); #1;
    chk("b in WAIT busy", 32'(b_busy), 32'h1);
    b_rst = 1'b0;
    @(posedge clk); #1;
    chk("b reset outputs", 32'({b_busy, b_if_gnt, b_mem_en, b_if_rvalid}), 32'h0);
    b_rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("b no stale rvalid %0d", k), 32'({b_if_rvalid, b_d_rvalid, b_busy}), 32'h0);
    end
    chk("b if_rdata untouched", b_if_rdata, 32'h0);
    $display("reset-in-WAIT: aborted fetch produced no response");

    b_d_req = 1'b1; b_d_we = 1'b0; b_d_be = 4'hF; b_d_addr = 8'h08;
    @(posedge clk); #1;
    chk("b load gnt", 32'(b_d_gnt), 32'h1);
    b_d_req = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("b load rvalid +%0d", k), 32'(b_d_rvalid), (k == 4) ? 32'h1 : 32'h0);
      if (k == 4) chk("b load d_rdata", b_d_rdata, 32'hCAFEF00D);
    end
    $display("reset-in-WAIT: following load returned %h", b_d_rdata);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
